// File: rtl/multiword_add_seq.sv
// Sequential multi-precision add/subtract built around one shared N-bit slice.
// Carries ripple between cycles; flags describe the full W-bit result.
module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   result,
    output logic                 carry,
    output logic                 overflow,
    output logic                 zero,
    output logic                 busy
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nx;
    logic [IW-1:0]  idx;
    logic           c_reg;
    logic           z_acc;
    logic [N-1:0]   sl_a;
    logic [N-1:0]   sl_b;
    logic [N-1:0]   s;
    logic           c;
    logic           last;
    logic           accept;

    assign sl_a   = op_a[idx*N +: N];
    assign sl_b   = op_b[idx*N +: N];
    assign {c, s} = {1'b0, sl_a} + {1'b0, sl_b} + {{N{1'b0}}, c_reg};
    assign last   = (idx == IW'(WORDS - 1));
    assign accept = (state == IDLE) && in_valid;

    // Partial sums stay internal until the final slice lands.
    always_comb begin
        acc_nx = acc;
        acc_nx[idx*N +: N] = s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            idx      <= '0;
            c_reg    <= 1'b0;
            z_acc    <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            c_reg <= sub;
            idx   <= '0;
            z_acc <= 1'b1;
            acc   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nx;
            c_reg <= c;
            z_acc <= z_acc && (s == '0);
            if (!last) idx <= idx + IW'(1);
            if (last) begin
                result   <= acc_nx;
                carry    <= c;
                overflow <= (op_a[W-1] == op_b[W-1]) && (s[N-1] != op_a[W-1]);
                zero     <= z_acc && (s == '0);
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: a 4-slice and a 1-slice instance.
// Expected values are hand-computed constants.
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid, sub, out_ready;
    logic [31:0] a, b, result;
    logic        in_ready, out_valid, carry, overflow, zero, busy;

    logic        in_valid1, sub1, out_ready1;
    logic [7:0]  a1, b1, result1;
    logic        in_ready1, out_valid1, carry1, overflow1, zero1, busy1;

    always #5 clk = ~clk;

    multiword_add_seq #(.N(8), .WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .busy(busy)
    );

    multiword_add_seq #(.N(8), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .result(result1), .carry(carry1),
        .overflow(overflow1), .zero(zero1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the 4-slice instance and check result/flags.
    task automatic op4(input string tag, input logic [31:0] av,
                       input logic [31:0] bv, input logic sv,
                       input logic [31:0] er, input logic ec,
                       input logic ev, input logic ez, input logic rel);
        int n;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = av; b = bv; sub = sv;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_flags"}, {61'd0, carry, overflow, zero},
            {61'd0, ec, ev, ez});
        if (rel) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
        end
    endtask

    task automatic op1(input string tag, input logic [7:0] av,
                       input logic [7:0] bv, input logic sv,
                       input logic [7:0] er, input logic ec,
                       input logic ev, input logic ez);
        in_valid1 = 1'b1; a1 = av; b1 = bv; sub1 = sv;
        tick();
        in_valid1 = 1'b0;
        a1 = 8'h55; b1 = 8'h33;
        tick();
        chk({tag, "_valid"}, 64'(out_valid1), 64'd1);
        chk({tag, "_result"}, 64'(result1), 64'(er));
        chk({tag, "_flags"}, {61'd0, carry1, overflow1, zero1},
            {61'd0, ec, ev, ez});
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk({tag, "_idle"}, 64'(in_ready1), 64'd1);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b0;
        tick();
        tick();
        chk("reset_outs", {result, out_valid, carry, overflow, zero, busy},
            '0);
        rst_n = 1'b1;
        tick();
        chk("reset_ready", 64'(in_ready), 64'd1);

        op4("add_ff", 32'h000000FF, 32'h1, 1'b0, 32'h100, 0, 0, 0, 1);
        op4("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1, 0, 1, 1);
        op4("sovf", 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 0, 1, 0, 1);
        op4("sub_eq", 32'd5, 32'd5, 1'b1, 32'h0, 1, 0, 1, 1);
        op4("sub_neg", 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 0, 0, 0, 1);
        op4("sub_ovf", 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1, 1, 0, 0);

        // Backpressure: stay in DONE while the requester keeps pushing.
        held = result;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i); a = $urandom; b = $urandom; sub = 1'(i >> 1);
            tick();
        end
        chk("bp_result", 64'(result), 64'(held));
        chk("bp_flags", {61'd0, carry, overflow, zero}, 64'b110);
        chk("bp_hs", {61'd0, in_ready, out_valid, busy}, 64'b011);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {61'd0, in_ready, out_valid, busy}, 64'b100);
        tick();
        chk("bp_no_accept", 64'(in_ready), 64'd1);

        // Reset during the second RUN cycle aborts the operation.
        in_valid = 1'b1; a = 32'h12345678; b = 32'h11111111; sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_outs",
            {result, out_valid, carry, overflow, zero, busy, in_ready},
            64'd1);
        tick();
        chk("rst_mid_novalid", 64'(out_valid), 64'd0);
        op4("after_rst", 32'd1, 32'd2, 1'b0, 32'd3, 0, 0, 0, 1);

        op1("w1_add", 8'h80, 8'h80, 1'b0, 8'h00, 1, 1, 1);
        op1("w1_sub", 8'h80, 8'h80, 1'b1, 8'h00, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
